// File: rtl/alu_sched_pkg.sv
// Shared types and defaults for the round-robin ALU scheduler.
package alu_sched_pkg;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } alu_op_e;

  typedef struct packed {
    alu_op_e             ctl;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic                ci;
  } alu_req_t;

endpackage

// File: rtl/alu_sched_tagq.sv
// Tag FIFO remembering which requester issued each in-flight ALU operation.
module alu_sched_tagq
  import alu_sched_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [$clog2(NREQ)-1:0]      din,
  output logic [$clog2(NREQ)-1:0]      head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned TW = $clog2(NREQ);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [TW-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= (wp == PW'(DEPTH-1)) ? '0 : wp + 1'b1;
      if (pop)  rp <= (rp == PW'(DEPTH-1)) ? '0 : rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rp];

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU among NREQ requesters, with in-order result routing.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_push,
  output logic [NREQ-1:0]              req_stop,
  input  logic [2*NREQ-1:0]            req_ctl,
  input  logic [8*NREQ-1:0]            req_a,
  input  logic [8*NREQ-1:0]            req_b,
  input  logic [NREQ-1:0]              req_ci,
  output logic [NREQ-1:0]              rsp_push,
  input  logic [NREQ-1:0]              rsp_stop,
  output logic [7:0]                   rsp_z,
  output logic                         rsp_cout,
  output logic                         alu_pushin,
  output logic [1:0]                   alu_ctl,
  output logic [7:0]                   alu_a,
  output logic [7:0]                   alu_b,
  output logic                         alu_ci,
  input  logic                         alu_stopout,
  input  logic                         alu_pushout,
  input  logic [7:0]                   alu_z,
  input  logic                         alu_cout,
  output logic                         alu_stopin,
  output logic [$clog2(DEPTH+1)-1:0]   inflight,
  output logic                         err
);

  localparam int unsigned TW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [TW-1:0] rr_ptr;
  logic [TW-1:0] gnt;
  logic          found;
  int unsigned   cand;
  logic          issue_ok;
  alu_req_t      sel;
  logic [TW-1:0] head;
  logic          empty;
  logic          hit;
  logic          pop;

  // First pushing requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(rr_ptr) + k) % NREQ;
      if (!found && req_push[TW'(cand)]) begin
        found = 1'b1;
        gnt   = TW'(cand);
      end
    end
  end

  always_comb begin
    sel = '0;
    if (found) begin
      sel.ctl = alu_op_e'(req_ctl[2*32'(gnt) +: 2]);
      sel.a   = req_a[8*32'(gnt) +: 8];
      sel.b   = req_b[8*32'(gnt) +: 8];
      sel.ci  = req_ci[gnt];
    end
  end

  assign issue_ok   = (inflight < CW'(DEPTH)) && !alu_stopout;
  assign alu_pushin = issue_ok && found;
  assign alu_ctl    = 2'(sel.ctl);
  assign alu_a      = sel.a;
  assign alu_b      = sel.b;
  assign alu_ci     = sel.ci;

  always_comb begin
    req_stop = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_stop[i] = req_push[i] && !(found && (gnt == TW'(i)) && issue_ok);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (alu_pushin) begin
      rr_ptr <= (gnt == TW'(NREQ-1)) ? '0 : gnt + 1'b1;
    end
  end

  alu_sched_tagq #(.NREQ(NREQ), .DEPTH(DEPTH)) u_tagq (
    .clk   (clk),
    .rst   (rst),
    .push  (alu_pushin),
    .pop   (pop),
    .din   (gnt),
    .head  (head),
    .count (inflight)
  );

  // Results are routed to the oldest tag; a result with no tag is an error.
  assign empty      = (inflight == '0);
  assign hit        = alu_pushout && !empty;
  assign rsp_push   = hit ? (NREQ'(1) << head) : '0;
  assign alu_stopin = hit && rsp_stop[head];
  assign pop        = hit && !rsp_stop[head];
  assign rsp_z      = alu_z;
  assign rsp_cout   = alu_cout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (alu_pushout && empty) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a two-entry behavioural ALU attached.
module tb_alu_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_push;
  logic [3:0]  req_stop;
  logic [7:0]  req_ctl;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ci;
  logic [3:0]  rsp_push;
  logic [3:0]  rsp_stop;
  logic [7:0]  rsp_z;
  logic        rsp_cout;
  logic        alu_pushin;
  logic [1:0]  alu_ctl;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_ci;
  logic        alu_stopout;
  logic        alu_pushout;
  logic [7:0]  alu_z;
  logic        alu_cout;
  logic        alu_stopin;
  logic [1:0]  inflight;
  logic        err;
  logic        force_po;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sched dut (
    .clk(clk), .rst(rst),
    .req_push(req_push), .req_stop(req_stop), .req_ctl(req_ctl),
    .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
    .rsp_push(rsp_push), .rsp_stop(rsp_stop), .rsp_z(rsp_z), .rsp_cout(rsp_cout),
    .alu_pushin(alu_pushin), .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ci(alu_ci), .alu_stopout(alu_stopout), .alu_pushout(alu_pushout),
    .alu_z(alu_z), .alu_cout(alu_cout), .alu_stopin(alu_stopin),
    .inflight(inflight), .err(err)
  );

  // Behavioural ALU: result visible the cycle after acceptance, two results buffered.
  logic [8:0] m_q [2];
  logic [1:0] m_cnt;
  logic       m_push;
  logic       m_pop;
  logic [1:0] m_wr;

  function automatic logic [8:0] alu_fn(input logic [1:0] c, input logic [7:0] a,
                                        input logic [7:0] b, input logic ci);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (c)
      2'd0:    return {1'b0, a};
      2'd1:    return 9'(a) + 9'(b) + 9'(ci);
      2'd2:    return 9'(a) - 9'(b) - 9'(ci);
      default: return {|p[15:8], p[7:0]};
    endcase
  endfunction

  assign alu_stopout = (m_cnt == 2'd2);
  assign m_push      = alu_pushin && !alu_stopout;
  assign m_pop       = (m_cnt != 2'd0) && !alu_stopin;
  assign m_wr        = m_pop ? m_cnt - 2'd1 : m_cnt;
  assign alu_pushout = (m_cnt != 2'd0) || force_po;
  assign alu_z       = m_q[0][7:0];
  assign alu_cout    = m_q[0][8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt <= 2'd0;
    end else begin
      if (m_pop)  m_q[0] <= m_q[1];
      if (m_push) m_q[m_wr[0]] <= alu_fn(alu_ctl, alu_a, alu_b, alu_ci);
      m_cnt <= m_cnt + 2'(m_push) - 2'(m_pop);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs;
    req_push = '0; req_ctl = '0; req_a = '0; req_b = '0; req_ci = '0;
  endtask

  task automatic set_req(input int i, input logic [1:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic ci);
    req_push[i]      = 1'b1;
    req_ctl[2*i +: 2] = c;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_ci[i]        = ci;
  endtask

  task automatic do_reset;
    clear_reqs();
    rsp_stop = '0;
    force_po = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  typedef struct {
    int         idx;
    logic [1:0] ctl;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] z;
    logic       co;
  } vec_t;

  vec_t vecs [7];
  int   rr_exp [5];

  initial begin
    vecs[0] = '{2, 2'd1, 8'h10, 8'h05, 1'b1, 8'h16, 1'b0};
    vecs[1] = '{0, 2'd2, 8'h05, 8'h06, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{1, 2'd0, 8'hA5, 8'h33, 1'b0, 8'hA5, 1'b0};
    vecs[3] = '{3, 2'd3, 8'h10, 8'h10, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{0, 2'd1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{3, 2'd3, 8'h0F, 8'h11, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{1, 2'd2, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
    rr_exp  = '{0, 1, 2, 3, 0};

    clear_reqs();
    rsp_stop = '0;
    force_po = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("reset rsp_push", 32'(rsp_push), 32'h0);
    chk("reset alu_pushin", 32'(alu_pushin), 32'h0);
    chk("reset alu_stopin", 32'(alu_stopin), 32'h0);
    chk("reset inflight", 32'(inflight), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Single operations, one requester at a time.
    for (int v = 0; v < 7; v++) begin
      clear_reqs();
      set_req(vecs[v].idx, vecs[v].ctl, vecs[v].a, vecs[v].b, vecs[v].ci);
      @(negedge clk);
      chk($sformatf("v%0d req_stop", v), 32'(req_stop), 32'h0);
      chk($sformatf("v%0d alu_pushin", v), 32'(alu_pushin), 32'h1);
      chk($sformatf("v%0d alu_a", v), 32'(alu_a), 32'(vecs[v].a));
      tick();
      clear_reqs();
      @(negedge clk);
      chk($sformatf("v%0d rsp_push", v), 32'(rsp_push), 32'(oh(vecs[v].idx)));
      chk($sformatf("v%0d rsp_z", v), 32'(rsp_z), 32'(vecs[v].z));
      chk($sformatf("v%0d rsp_cout", v), 32'(rsp_cout), 32'(vecs[v].co));
      chk($sformatf("v%0d inflight busy", v), 32'(inflight), 32'h1);
      tick();
      @(negedge clk);
      chk($sformatf("v%0d inflight idle", v), 32'(inflight), 32'h0);
      chk($sformatf("v%0d rsp_push idle", v), 32'(rsp_push), 32'h0);
      tick();
    end

    // Round robin with all four requesters pushing continuously.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 2'd1, 8'(i), 8'h10, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("rr%0d req_stop", c), 32'(req_stop), 32'(4'hF & ~oh(rr_exp[c])));
      if (c > 0) begin
        chk($sformatf("rr%0d rsp_push", c), 32'(rsp_push), 32'(oh(rr_exp[c-1])));
        chk($sformatf("rr%0d rsp_z", c), 32'(rsp_z), 32'(8'h10 + 8'(rr_exp[c-1])));
        chk($sformatf("rr%0d inflight", c), 32'(inflight), 32'h1);
      end
      tick();
    end
    clear_reqs();
    @(negedge clk);
    chk("rr tail rsp_push", 32'(rsp_push), 32'(oh(0)));
    tick();
    @(negedge clk);
    chk("rr drained", 32'(inflight), 32'h0);
    tick();

    // Response stall on requester 1 with a second result queued behind it.
    do_reset();
    set_req(1, 2'd3, 8'h10, 8'h10, 1'b0);
    @(negedge clk);
    chk("stall issue1", 32'(req_stop), 32'h0);
    tick();
    clear_reqs();
    set_req(3, 2'd1, 8'h01, 8'h02, 1'b0);
    rsp_stop = 4'b0010;
    @(negedge clk);
    chk("stall issue3", 32'(req_stop), 32'h0);
    chk("stall alu_stopin", 32'(alu_stopin), 32'h1);
    tick();
    set_req(0, 2'd0, 8'h77, 8'h00, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d rsp_push", c), 32'(rsp_push), 32'h2);
      chk($sformatf("stall%0d rsp_z", c), 32'(rsp_z), 32'h00);
      chk($sformatf("stall%0d rsp_cout", c), 32'(rsp_cout), 32'h1);
      chk($sformatf("stall%0d inflight", c), 32'(inflight), 32'h2);
      chk($sformatf("stall%0d req_stop", c), 32'(req_stop), 32'h9);
      tick();
    end
    clear_reqs();
    rsp_stop = '0;
    @(negedge clk);
    chk("unstall rsp_push1", 32'(rsp_push), 32'h2);
    chk("unstall alu_stopin", 32'(alu_stopin), 32'h0);
    tick();
    @(negedge clk);
    chk("follow rsp_push3", 32'(rsp_push), 32'h8);
    chk("follow rsp_z", 32'(rsp_z), 32'h03);
    chk("follow inflight", 32'(inflight), 32'h1);
    tick();
    @(negedge clk);
    chk("stall drained", 32'(inflight), 32'h0);
    tick();

    // Reset in the middle of a stalled result.
    do_reset();
    set_req(2, 2'd1, 8'h01, 8'h01, 1'b0);
    tick();
    clear_reqs();
    rsp_stop = 4'b0100;
    @(negedge clk);
    chk("mid inflight", 32'(inflight), 32'h1);
    chk("mid rsp_push", 32'(rsp_push), 32'h4);
    #2 rst = 1'b0;
    #1;
    chk("mid rst rsp_push", 32'(rsp_push), 32'h0);
    chk("mid rst inflight", 32'(inflight), 32'h0);
    chk("mid rst alu_stopin", 32'(alu_stopin), 32'h0);
    rsp_stop = '0;
    set_req(1, 2'd0, 8'h11, 8'h00, 1'b0);
    set_req(3, 2'd0, 8'h33, 8'h00, 1'b0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("post rst grant", 32'(req_stop), 32'h8);
    chk("post rst pushin", 32'(alu_pushin), 32'h1);
    tick();
    clear_reqs();
    @(negedge clk);
    chk("post rst rsp_push", 32'(rsp_push), 32'h2);
    chk("post rst rsp_z", 32'(rsp_z), 32'h11);
    tick();
    tick();

    // Spurious ALU result with the tag queue empty.
    force_po = 1'b1;
    @(negedge clk);
    chk("spur rsp_push", 32'(rsp_push), 32'h0);
    chk("spur alu_stopin", 32'(alu_stopin), 32'h0);
    tick();
    force_po = 1'b0;
    @(negedge clk);
    chk("spur err set", 32'(err), 32'h1);
    repeat (3) tick();
    @(negedge clk);
    chk("spur err sticky", 32'(err), 32'h1);
    chk("spur rsp_push quiet", 32'(rsp_push), 32'h0);
    tick();
    do_reset();
    @(negedge clk);
    chk("err cleared", 32'(err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares one 8-bit ALU among NREQ requesters. It accepts operations from each requester over push/stop handshakes and issues them in order to the ALU. It records the issuing requester of each in-flight operation in a tag queue, then routes each ALU result back to that requester. It sits between the requester blocks and the ALU's pushin/stopout and pushout/stopin ports.

## Interface
- NREQ, 4, number of requesters (2..8)
- DEPTH, 2, tag-queue entries (max ALU operations in flight; ≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (clears all state while 0)
- req_push  in  NREQ  requester i presents an operation
- req_stop  out  NREQ  requester i must hold its operation this cycle
- req_ctl  in  2*NREQ  op of requester i: 0 pass a, 1 add, 2 sub, 3 mult
- req_a, req_b  in  8*NREQ  operands of requester i
- req_ci  in  NREQ  carry-in of requester i
- rsp_push  out  NREQ  result valid for requester i
- rsp_stop  in  NREQ  requester i refuses its result this cycle
- rsp_z  out  8  result data, shared by all requesters
- rsp_cout  out  1  result carry, shared by all requesters
- alu_pushin, alu_ctl[2], alu_a[8], alu_b[8], alu_ci  out  operation to ALU
- alu_stopout  in  1  ALU cannot accept
- alu_pushout, alu_z[8], alu_cout  in  result from ALU
- alu_stopin  out  1  backpressure to ALU
- inflight  out  $clog2(DEPTH+1)  tag-queue occupancy
- err  out  1  sticky: ALU result arrived with tag queue empty

## Operation
- Transfer on any handshake occurs when push=1 and stop=0 in the same cycle.
- issue_ok = (inflight < DEPTH) && !alu_stopout.
- Grant selection: first i with req_push[i]=1, searching from rr_ptr upward with wrap modulo NREQ. Purely combinational.
- alu_pushin = issue_ok && any req_push. The granted requester's ctl, a, b and ci drive the alu_* buses.
- When no requester is granted, the alu_* data buses are 0.
- req_stop[i] = req_push[i] && !(granted==i && issue_ok). req_stop[i] is 0 when req_push[i]=0.
- On an issue (alu_pushin && !alu_stopout), the granted index is pushed into the tag queue and rr_ptr becomes (granted+1) mod NREQ.
- If nothing is issued, rr_ptr holds.
- Response routing: head = tag at queue head.
  - rsp_push[head] = alu_pushout; all other rsp_push bits are 0.
  - rsp_z = alu_z and rsp_cout = alu_cout, unconditionally.
  - alu_stopin = alu_pushout && rsp_stop[head].
  - Pop on alu_pushout && !rsp_stop[head].
- Push and pop in the same cycle: occupancy unchanged.
- Push is blocked only by occupancy, never relieved by a same-cycle pop.
- alu_pushout with queue empty: set err, rsp_push all 0, alu_stopin=0. err clears only on reset.
- Reset values:
  - rr_ptr=0, inflight=0, err=0, queue empty.
  - All rsp_push=0, alu_pushin=0, alu_stopin=0.
  - The ALU must be reset by the same event; its reset is active-high, so integration inverts rst.

## Timing
- Request to response is 1 cycle when unstalled. An operation accepted at edge k produces rsp_push at the requester after edge k (ALU input register).
- Throughput is one operation per cycle sustained when DEPTH≥2. With DEPTH=1, issue is blocked on cycles where the previous result is still in flight.
- Combinational paths:
  - alu_stopout → req_stop.
  - rsp_stop → alu_stopin.
  - alu_pushout → rsp_push.
- No combinational path from alu_stopin to alu_pushin.
- Fairness: a continuously pushing requester is granted within NREQ issues.
- Results return in issue order. The ALU holds its operation while alu_stopin=1, so a stalled result blocks all later results.

## Structure
- Package alu_sched_pkg holds:
  - the ctl enum alu_op_e: OP_PASS=0, OP_ADD=1, OP_SUB=2, OP_MUL=3;
  - the typedef alu_req_t {ctl, a, b, ci};
  - the default NREQ and DEPTH.
- Sub-module alu_sched_tagq is a synchronous FIFO of $clog2(NREQ)-bit tags, DEPTH entries.
  - Ports: push, pop, din, head, count.
  - Write and read pointers wrap modulo DEPTH.

## Test plan
- Single op: req 2 pushes add, a=8'h10, b=8'h05, ci=1 → req_stop[2]=0; next cycle rsp_push[2]=1, rsp_z=8'h16, rsp_cout=0, inflight returns to 0 after pop.
- Round-robin: reqs 0..3 push continuously, all stops 0, rr_ptr=0 → grants in order 0,1,2,3,0 on consecutive cycles; each rsp_push follows its grant by 1 cycle.
- Response stall: req 1 issues mult, 8'h10*8'h10, then req 3 issues an op; rsp_stop[1]=1 for 3 cycles → rsp_z=8'h00 and rsp_cout=1 held for req 1; inflight=2 (DEPTH=2); req_stop=1 for all pushers; req 3's result follows on the cycle after rsp_stop[1] drops.
- Sub and pass: sub, a=8'h05, b=8'h06, ci=0 → z=8'hFF, cout=1; pass, a=8'hA5 → z=8'hA5, cout=0.
- Reset mid-flight: rst=0 while inflight=1 and rsp_stop asserted → immediately all rsp_push=0, inflight=0, rr_ptr=0; the first grant after release goes to the lowest pushing index.
- Spurious result: force alu_pushout=1 with queue empty → err=1, stays 1 until reset, no rsp_push bit asserted.
